decodificador_pt2272: RTL and testbench
=======================================

// Module: decodificador_pt2272
// PURPOSE
//  Receiver for the PT2262-style serial code: recovers the 12 trinary symbols
//  (A0..A7, D3..D0) from cod_i by pulse-width measurement at the 3 MHz clk.
//  Checks the address against a local trinary setting, requires two consecutive
//  identical good frames, then latches data and raises vt.
//  Sits on the receive side of the link, driven by the encoder's cod_o.
// PARAMETERS
//  HIGH_MIN   300     min high-pulse width, clk cycles (shorter = glitch/error)
//  HIGH_THR   2000    high width < HIGH_THR = short (4 osc); >= = long (12 osc)
//  HIGH_MAX   4000    max high-pulse width; longer = error
//  LOW_MAX    4000    max low gap between pulses inside a frame
//  SYNC_MIN   20000   low width that qualifies as a sync gap (nominal 31000)
//  VT_TIMEOUT 400000  clk cycles without a good frame before vt drops
// PORTS
//  clk       in   1   3 MHz system clock
//  reset     in   1   reset, asynchronous, active-high
//  cod_i     in   1   serial coded input (asynchronous)
//  addr_cfg  in   16  local address, 2 bits/symbol: 00=0, 11=1, 01=F; [1:0]=A0
//  data_o    out  4   latched data {D3,D2,D1,D0}
//  vt        out  1   valid transmission (level)
//  sync_det  out  1   1-clk pulse when a sync gap is qualified
//  frame_ok  out  1   1-clk pulse on a good frame (valid + address match)
//  err       out  1   1-clk pulse on a malformed frame or address mismatch
// BEHAVIOUR
//  - Reset: data_o=0, vt=0, sync_det=0, frame_ok=0, err=0, state HUNT, counters 0,
//    candidate cleared. Reset mid-frame discards all partial data.
//  - cod_i through 2-flop synchronizer; all widths measured on synchronized
//    signal (2 clk latency). Width counter 16 bits, saturating at 65535.
//  - FSM: HUNT -> (low >= SYNC_MIN) -> WAIT_HI -> rising -> MEAS_HI -> falling
//    -> MEAS_LO -> rising -> MEAS_HI (next half), or low reaches SYNC_MIN -> END.
//  - HUNT: ignore everything until low width reaches SYNC_MIN; then sync_det.
//  - Each high pulse = one half-symbol: HIGH_MIN<=w<HIGH_THR -> 0, HIGH_THR<=w<=HIGH_MAX
//    -> 1; outside -> err, go HUNT. Halves pair in order: 00=0, 11=1, 01=F,
//    10=invalid (err, HUNT at symbol end).
//  - Low gap > LOW_MAX before the 24th half: err; if it continues to SYNC_MIN, it
//    counts as sync (sync_det, WAIT_HI), else HUNT.
//  - Symbol order: 1st..8th = A0..A7 vs addr_cfg[2i+1:2i]; 9th..12th = D3..D0.
//  - END (low after 24th half reaches SYNC_MIN), same clk: sync_det=1, evaluate:
//    good = all 12 valid, A match, D symbols not F. Good -> frame_ok, else err.
//    The same sync gap starts the next frame (-> WAIT_HI, no extra sync needed).
//  - A 25th high pulse before SYNC_MIN -> err, HUNT.
//  - Double-frame rule: good frame with data == candidate -> data_o<=data, vt<=1
//    (registered on the END clk edge, visible next clk); differing data ->
//    candidate<=data, vt<=0, data_o held; err frame -> candidate cleared, vt held.
//  - vt timer reloads on every good frame; expiry -> vt=0, candidate cleared;
//    data_o held. frame_ok and err never assert in the same cycle.
// TESTING
//  - Encoder-nominal frames, addr_cfg=16'hFFFF (all 1), D=4'b1010, 2 frames ->
//    frame_ok x2, after 2nd vt=1, data_o=4'hA; single frame -> vt stays 0.
//  - addr_cfg with F symbols (16'h5500) matched by encoder, D=4'h3 -> vt=1,
//    data_o=3; flip one A symbol F->0 -> err pulse, no frame_ok.
//  - Alternate D=5, D=6 frames -> vt never rises; then two D=6 -> vt=1, data_o=6.
//  - Stop input after vt=1 -> vt falls VT_TIMEOUT clk after last frame_ok; data_o kept.
//  - 100-clk glitch mid-frame and 6000-clk high pulse -> err, resync at next
//    sync, following two good frames give vt=1.
//  - Reset asserted mid-frame with vt=1 -> all outputs 0 immediately; recovery
//    needs sync + 2 good frames.

Source files
------------

// File: rtl/decodificador_pt2272.sv
// decodificador_pt2272
//   Receiver for PT2262-style trinary serial code. Recovers 12 trinary symbols
//   (A0..A7, D3..D0) from cod_i by measuring pulse widths in clk cycles. It
//   checks the address against addr_cfg and requires two consecutive identical
//   good frames before it latches the data and raises vt.
// Ports
//   clk       3 MHz system clock
//   reset     asynchronous, active-high
//   cod_i     serial coded input (asynchronous to clk)
//   addr_cfg  local address, 2 bits/symbol: 00=0, 11=1, 01=F; [1:0]=A0
//   data_o    latched data {D3,D2,D1,D0}
//   vt        valid transmission (level)
//   sync_det  1-clk pulse when a sync gap is qualified
//   frame_ok  1-clk pulse on a good frame
//   err       1-clk pulse on a malformed frame or address mismatch
module decodificador_pt2272 #(
  parameter int unsigned HIGH_MIN   = 300,
  parameter int unsigned HIGH_THR   = 2000,
  parameter int unsigned HIGH_MAX   = 4000,
  parameter int unsigned LOW_MAX    = 4000,
  parameter int unsigned SYNC_MIN   = 20000,
  parameter int unsigned VT_TIMEOUT = 400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cod_i,
  input  logic [15:0] addr_cfg,
  output logic [3:0]  data_o,
  output logic        vt,
  output logic        sync_det,
  output logic        frame_ok,
  output logic        err
);

  localparam logic [15:0] HMIN    = 16'(HIGH_MIN);
  localparam logic [15:0] HTHR    = 16'(HIGH_THR);
  localparam logic [15:0] HMAX    = 16'(HIGH_MAX);
  localparam logic [15:0] LMAX    = 16'(LOW_MAX);
  localparam logic [15:0] SYNC_M1 = 16'(SYNC_MIN - 1);
  localparam int unsigned TW      = $clog2(VT_TIMEOUT + 1);
  localparam logic [TW-1:0] VT_LOAD = TW'(VT_TIMEOUT);

  typedef enum logic [1:0] {HUNT, WAIT_HI, MEAS_HI, MEAS_LO} state_t;
  state_t state, state_n;

  logic        cod_s1, cod_s2, cod_p;
  logic [15:0] cnt;
  logic        rise, fall, hi_over, lo_over, lo_sync;

  logic [4:0]  half_cnt, half_n;
  logic        first_h, first_n;
  logic [3:0]  dsym, dsym_n;
  logic        d_f, df_n;
  logic        a_miss, amiss_n;
  logic        sync_n, ok_n, err_n;
  logic        hbit, hvalid;
  logic [1:0]  pair, cfg_sym;
  logic [3:0]  sel;

  logic [3:0]    cand;
  logic          cand_v;
  logic [TW-1:0] vt_tmr;

  // cnt holds the run length of cod_p's level; on an edge cycle it is the
  // width of the level that just ended.
  assign rise    = cod_s2 & ~cod_p;
  assign fall    = ~cod_s2 & cod_p;
  assign hi_over = cod_s2 & cod_p & (cnt == HMAX);
  assign lo_over = ~cod_s2 & ~cod_p & (cnt == LMAX);
  assign lo_sync = ~cod_s2 & ~cod_p & (cnt == SYNC_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cod_s1 <= 1'b0;
      cod_s2 <= 1'b0;
      cod_p  <= 1'b0;
      cnt    <= '0;
    end else begin
      cod_s1 <= cod_i;
      cod_s2 <= cod_s1;
      cod_p  <= cod_s2;
      if (cod_s2 != cod_p)
        cnt <= 16'd1;
      else if (cnt != '1)
        cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    state_n = state;
    half_n  = half_cnt;
    first_n = first_h;
    dsym_n  = dsym;
    df_n    = d_f;
    amiss_n = a_miss;
    sync_n  = 1'b0;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    hbit    = (cnt >= HTHR);
    hvalid  = (cnt >= HMIN) && (cnt <= HMAX);
    pair    = {first_h, hbit};
    // The pair code {first,second} shares the addr_cfg encoding directly.
    sel     = {half_cnt[3:1], 1'b0};
    cfg_sym = addr_cfg[sel +: 2];

    case (state)
      HUNT: begin
        if (lo_sync) begin
          sync_n  = 1'b1;
          state_n = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rise) begin
          state_n = MEAS_HI;
          half_n  = '0;
          dsym_n  = '0;
          df_n    = 1'b0;
          amiss_n = 1'b0;
        end
      end
      MEAS_HI: begin
        if (hi_over) begin
          err_n   = 1'b1;
          state_n = HUNT;
        end else if (fall) begin
          if (!hvalid) begin
            err_n   = 1'b1;
            state_n = HUNT;
          end else if (!half_cnt[0]) begin
            first_n = hbit;
            half_n  = half_cnt + 5'd1;
            state_n = MEAS_LO;
          end else if (pair == 2'b10) begin
            err_n   = 1'b1;
            state_n = HUNT;
          end else begin
            half_n  = half_cnt + 5'd1;
            state_n = MEAS_LO;
            if (!half_cnt[4]) begin
              if (cfg_sym != pair)
                amiss_n = 1'b1;
            end else begin
              dsym_n = {dsym[2:0], hbit};
              if (pair == 2'b01)
                df_n = 1'b1;
            end
          end
        end
      end
      MEAS_LO: begin
        if (half_cnt == 5'd24) begin
          if (rise) begin
            err_n   = 1'b1;
            state_n = HUNT;
          end else if (lo_sync) begin
            // Frame end; this same gap is the sync for the next frame.
            sync_n  = 1'b1;
            state_n = WAIT_HI;
            if (!a_miss && !d_f)
              ok_n = 1'b1;
            else
              err_n = 1'b1;
          end
        end else begin
          if (rise)
            state_n = MEAS_HI;
          else if (lo_over) begin
            err_n   = 1'b1;
            state_n = HUNT;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HUNT;
      half_cnt <= '0;
      first_h  <= 1'b0;
      dsym     <= '0;
      d_f      <= 1'b0;
      a_miss   <= 1'b0;
      sync_det <= 1'b0;
      frame_ok <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      half_cnt <= half_n;
      first_h  <= first_n;
      dsym     <= dsym_n;
      d_f      <= df_n;
      a_miss   <= amiss_n;
      sync_det <= sync_n;
      frame_ok <= ok_n;
      err      <= err_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_o <= '0;
      vt     <= 1'b0;
      cand   <= '0;
      cand_v <= 1'b0;
      vt_tmr <= '0;
    end else if (ok_n) begin
      vt_tmr <= VT_LOAD;
      if (cand_v && (dsym == cand)) begin
        data_o <= dsym;
        vt     <= 1'b1;
      end else begin
        cand   <= dsym;
        cand_v <= 1'b1;
        vt     <= 1'b0;
      end
    end else begin
      if (err_n) begin
        cand   <= '0;
        cand_v <= 1'b0;
      end
      if (vt_tmr != '0) begin
        vt_tmr <= vt_tmr - 1'b1;
        if (vt_tmr == TW'(1)) begin
          vt     <= 1'b0;
          cand   <= '0;
          cand_v <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_decodificador_pt2272.sv
// Testbench for decodificador_pt2272 with scaled-down timing parameters.
// Oscillator period = 3 clk: short high 12, long high 36, sync gap 372.
module tb_decodificador_pt2272;

  localparam int unsigned OSC      = 3;
  localparam int unsigned VT_TO    = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cod_i;
  logic [15:0] addr_cfg;
  logic [3:0]  data_o;
  logic        vt, sync_det, frame_ok, err;

  always #5 clk = ~clk;

  decodificador_pt2272 #(
    .HIGH_MIN(4),
    .HIGH_THR(24),
    .HIGH_MAX(48),
    .LOW_MAX(48),
    .SYNC_MIN(240),
    .VT_TIMEOUT(VT_TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cod_i(cod_i),
    .addr_cfg(addr_cfg),
    .data_o(data_o),
    .vt(vt),
    .sync_det(sync_det),
    .frame_ok(frame_ok),
    .err(err)
  );

  typedef struct packed {
    logic [1:0] kind;   // 1 = frame_ok, 2 = err
    logic       vt;
    logic [3:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   last_ok = 0;
  int   sync_cnt = 0;
  int   target;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    nvec++;
    assert (got === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (sync_det) sync_cnt++;
      if (frame_ok || err) begin
        check("ok_err_exclusive", 32'(frame_ok & err), 32'd0);
        if (q.size() == 0) begin
          check("unexpected_pulse", frame_ok ? 32'd1 : 32'd2, 32'd0);
        end else begin
          e_mon = q.pop_front();
          check("kind", frame_ok ? 32'd1 : 32'd2, 32'(e_mon.kind));
          check("vt", 32'(vt), 32'(e_mon.vt));
          check("data_o", 32'(data_o), 32'(e_mon.data));
        end
        if (frame_ok) last_ok = cyc;
      end
    end
  end

  task automatic drive(input logic v, input int unsigned n);
    cod_i = v;
    repeat (n) @(negedge clk);
  endtask

  // fault: 0 none, 1 short glitch inside the low of fault_half,
  //        2 over-long high on fault_half.
  task automatic send_frame(input logic [15:0] a, input logic [3:0] d,
                            input int fault, input int fault_half, input int nhalves,
                            input logic [1:0] ekind, input logic evt, input logic [3:0] edata);
    logic [1:0]  sym;
    logic        hb;
    int unsigned hw, lw;
    if (ekind != 2'd0) q.push_back(exp_t'{kind: ekind, vt: evt, data: edata});
    for (int h = 0; h < nhalves; h++) begin
      if (h < 16) sym = a[2*(h/2) +: 2];
      else        sym = d[3-(h-16)/2] ? 2'b11 : 2'b00;
      hb = (h % 2 == 0) ? sym[1] : sym[0];
      hw = hb ? 12*OSC : 4*OSC;
      lw = hb ? 4*OSC : 12*OSC;
      if (h == 23) lw = 124*OSC;
      if (fault == 2 && h == fault_half) hw = 100;
      drive(1'b1, hw);
      if (fault == 1 && h == fault_half) begin
        drive(1'b0, 5);
        drive(1'b1, 2);
        drive(1'b0, lw - 7);
      end else begin
        drive(1'b0, lw);
      end
    end
    if (nhalves == 24) check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    cod_i    = 1'b0;
    addr_cfg = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("rst_vt", 32'(vt), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_sync", 32'(sync_det), 32'd0);
    check("rst_ok", 32'(frame_ok), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    drive(1'b0, 300);

    // Two identical all-1 address frames, D=A
    send_frame(16'hFFFF, 4'hA, 0, 0, 24, 2'd1, 1'b0, 4'h0);
    check("sync_count", 32'(sync_cnt), 32'd2);
    check("single_frame_vt", 32'(vt), 32'd0);
    send_frame(16'hFFFF, 4'hA, 0, 0, 24, 2'd1, 1'b1, 4'hA);

    // Address with F symbols
    addr_cfg = 16'h5500;
    send_frame(16'h5500, 4'h3, 0, 0, 24, 2'd1, 1'b0, 4'hA);
    send_frame(16'h5500, 4'h3, 0, 0, 24, 2'd1, 1'b1, 4'h3);
    // A4 F -> 0: address mismatch
    send_frame(16'h5400, 4'h3, 0, 0, 24, 2'd2, 1'b1, 4'h3);

    // Alternating data never qualifies, then a repeat does
    send_frame(16'h5500, 4'h5, 0, 0, 24, 2'd1, 1'b0, 4'h3);
    send_frame(16'h5500, 4'h6, 0, 0, 24, 2'd1, 1'b0, 4'h3);
    send_frame(16'h5500, 4'h5, 0, 0, 24, 2'd1, 1'b0, 4'h3);
    send_frame(16'h5500, 4'h6, 0, 0, 24, 2'd1, 1'b0, 4'h3);
    send_frame(16'h5500, 4'h6, 0, 0, 24, 2'd1, 1'b1, 4'h6);

    // Input stops: vt times out, data held
    target = last_ok + int'(VT_TO) - 10;
    while (cyc < target) @(negedge clk);
    check("vt_before_timeout", 32'(vt), 32'd1);
    target = last_ok + int'(VT_TO) + 10;
    while (cyc < target) @(negedge clk);
    check("vt_after_timeout", 32'(vt), 32'd0);
    check("data_after_timeout", 32'(data_o), 32'd6);

    // Glitch mid-frame, then resync and two good frames
    addr_cfg = 16'hFFFF;
    send_frame(16'hFFFF, 4'h9, 1, 5, 24, 2'd2, 1'b0, 4'h6);
    send_frame(16'hFFFF, 4'h9, 0, 0, 24, 2'd1, 1'b0, 4'h6);
    send_frame(16'hFFFF, 4'h9, 0, 0, 24, 2'd1, 1'b1, 4'h9);

    // Over-long high pulse
    send_frame(16'hFFFF, 4'hC, 2, 10, 24, 2'd2, 1'b1, 4'h9);
    send_frame(16'hFFFF, 4'hC, 0, 0, 24, 2'd1, 1'b0, 4'h9);
    send_frame(16'hFFFF, 4'hC, 0, 0, 24, 2'd1, 1'b1, 4'hC);

    // Reset asserted mid-frame with vt=1
    send_frame(16'hFFFF, 4'hA, 0, 0, 10, 2'd0, 1'b0, 4'h0);
    cod_i = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_vt", 32'(vt), 32'd0);
    check("midrst_data", 32'(data_o), 32'd0);
    check("midrst_sync", 32'(sync_det), 32'd0);
    check("midrst_ok", 32'(frame_ok), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    @(negedge clk);
    cod_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 300);
    send_frame(16'hFFFF, 4'hA, 0, 0, 24, 2'd1, 1'b0, 4'h0);
    send_frame(16'hFFFF, 4'hA, 0, 0, 24, 2'd1, 1'b1, 4'hA);

    repeat (20) @(negedge clk);
    check("drain_final", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
